// File: rtl/nvm_snn_pkg.sv
// Shared types and default sizes for the NVM spiking-network readout blocks.
package nvm_snn_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } cls_state_e;

  localparam int DEF_NUM_OF_MACRO = 4;
  localparam int DEF_NUM_CLASSES  = 11;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_GRP_W        = 2;
  localparam int DEF_CLS_W        = 4;

  // One extra bit so the carry out of count+1 flags saturation.
  localparam int SAT_INC_W = DEF_CNT_W + 1;

endpackage

// File: rtl/nvm_sat_counter.sv
// One saturating up-counter with synchronous clear; clear wins over increment.
module nvm_sat_counter
  import nvm_snn_pkg::*;
#(
  parameter int W     = DEF_CNT_W,
  parameter int SUM_W = SAT_INC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(count) + SUM_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sum[W]) begin
      count <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/nvm_spike_classifier.sv
// Per-picture spike counting per class, then a sequential argmax with a valid/ready result.
// Optional second-best tracking and result_margin output: define CLASSIFIER_MARGIN_EN.
module nvm_spike_classifier
  import nvm_snn_pkg::*;
#(
  parameter int NUM_OF_MACRO = DEF_NUM_OF_MACRO,
  parameter int NUM_CLASSES  = DEF_NUM_CLASSES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int GRP_W        = DEF_GRP_W,
  parameter int CLS_W        = DEF_CLS_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_OF_MACRO-1:0] spike_i,
  input  logic                    spike_valid,
  input  logic [GRP_W-1:0]        group_idx,
  input  logic                    picture_done,
  output logic [CLS_W-1:0]        result_class,
  output logic [CNT_W-1:0]        result_count,
  output logic                    result_empty,
`ifdef CLASSIFIER_MARGIN_EN
  output logic [CNT_W-1:0]        result_margin,
`endif
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NUM_CLASSES + 1);

  // Handshake: result fields are valid while result_valid is high and stay put
  // until the cycle result_valid & result_ready, after which result_valid drops.
  cls_state_e             state, state_next;
  logic [IDX_W-1:0]       scan_idx;
  logic [CLS_W-1:0]       best_idx;
  logic [CNT_W-1:0]       best_count;
  logic [CNT_W-1:0]       cur_count;
  logic [CNT_W-1:0]       count [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] inc;
  logic                   accept;
  logic                   scan_last;
`ifdef CLASSIFIER_MARGIN_EN
  logic [CNT_W-1:0]       second_count;
`endif

  assign accept       = (state == HOLD) && result_ready;
  assign scan_last    = (scan_idx == IDX_W'(NUM_CLASSES));
  assign result_valid = (state == HOLD);
  assign busy         = (state != ACCUM);

  // Lane i of group g feeds class g*NUM_OF_MACRO+i; classes past the end have no counter.
  always_comb begin
    inc = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      inc[c] = (state == ACCUM) && spike_valid &&
               (group_idx == GRP_W'(c / NUM_OF_MACRO)) && spike_i[c % NUM_OF_MACRO];
    end
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cnt
    nvm_sat_counter #(
      .W     (CNT_W),
      .SUM_W (CNT_W + 1)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[c]),
      .clr   (accept),
      .count (count[c])
    );
  end

  always_comb begin
    cur_count = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (scan_idx == IDX_W'(c)) cur_count = count[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (picture_done) state_next = SCAN;
      SCAN:    if (scan_last)    state_next = HOLD;
      HOLD:    if (result_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // SCAN visits indices 0..NUM_CLASSES-1, then spends one more cycle latching the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx     <= '0;
      best_idx     <= '0;
      best_count   <= '0;
      result_class <= '0;
      result_count <= '0;
      result_empty <= 1'b0;
`ifdef CLASSIFIER_MARGIN_EN
      second_count  <= '0;
      result_margin <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (picture_done) begin
            scan_idx   <= '0;
            best_idx   <= '0;
            best_count <= '0;
`ifdef CLASSIFIER_MARGIN_EN
            second_count <= '0;
`endif
          end
        end
        SCAN: begin
          if (scan_last) begin
            result_class <= (best_count == '0) ? '0 : best_idx;
            result_count <= best_count;
            result_empty <= (best_count == '0);
`ifdef CLASSIFIER_MARGIN_EN
            result_margin <= best_count - second_count;
`endif
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
            // Strict compare keeps the lowest index on ties.
            if (cur_count > best_count) begin
              best_idx   <= CLS_W'(scan_idx);
              best_count <= cur_count;
`ifdef CLASSIFIER_MARGIN_EN
              second_count <= best_count;
`endif
            end
`ifdef CLASSIFIER_MARGIN_EN
            else if (cur_count > second_count) begin
              second_count <= cur_count;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_spike_classifier.sv
// Self-checking bench for nvm_spike_classifier: picture-level reference model plus directed literal checks.
module tb_nvm_spike_classifier;
  import nvm_snn_pkg::*;

  localparam int NM   = DEF_NUM_OF_MACRO;
  localparam int NC   = DEF_NUM_CLASSES;
  localparam int CW   = DEF_CNT_W;
  localparam int GW   = DEF_GRP_W;
  localparam int LW   = DEF_CLS_W;
  localparam int CMAX = (1 << CW) - 1;
  localparam int EW   = 2 * CW + 1 + LW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0] spike_i = '0;
  logic          spike_valid = 1'b0;
  logic [GW-1:0] group_idx = '0;
  logic          picture_done = 1'b0;
  logic [LW-1:0] result_class;
  logic [CW-1:0] result_count;
  logic          result_empty;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          busy;
`ifdef CLASSIFIER_MARGIN_EN
  logic [CW-1:0] result_margin;
`endif

  nvm_spike_classifier dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spike_i      (spike_i),
    .spike_valid  (spike_valid),
    .group_idx    (group_idx),
    .picture_done (picture_done),
    .result_class (result_class),
    .result_count (result_count),
    .result_empty (result_empty),
`ifdef CLASSIFIER_MARGIN_EN
    .result_margin(result_margin),
`endif
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase 0 = collecting spikes, 1 = result pending, 2 = result presented.
  int m_cnt [NC];
  int m_phase = 0;
  int m_wait = 0;
  int m_class = 0, m_count = 0, m_empty = 0, m_margin = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] judge();
    int best = 0;
    int bc = 0;
    int mg;
    int q[$];
    for (int c = 0; c < NC; c++) begin
      if (m_cnt[c] > bc) begin
        best = c;
        bc   = m_cnt[c];
      end
      q.push_back(m_cnt[c]);
    end
    q.rsort();
    mg = (NC == 1) ? q[0] : q[0] - q[1];
    return {CW'(mg), (bc == 0), CW'(bc), LW'(best)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) m_cnt[c] = 0;
      m_phase = 0; m_wait = 0;
      m_class = 0; m_count = 0; m_empty = 0; m_margin = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          if (spike_valid) begin
            for (int i = 0; i < NM; i++) begin
              int c;
              c = int'(group_idx) * NM + i;
              if (c < NC && spike_i[i]) m_cnt[c] = (m_cnt[c] >= CMAX) ? CMAX : m_cnt[c] + 1;
            end
          end
          if (picture_done) begin
            exp_q.push_back(judge());
            m_wait  = NC + 1;
            m_phase = 1;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            m_class  = int'(e[LW-1:0]);
            m_count  = int'(e[LW+CW-1:LW]);
            m_empty  = int'(e[LW+CW]);
            m_margin = int'(e[EW-1:LW+CW+1]);
            m_phase  = 2;
          end
        end
        default: begin
          if (result_ready) begin
            for (int c = 0; c < NC; c++) m_cnt[c] = 0;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("valid", int'(result_valid), int'(m_phase == 2));
    check("busy", int'(busy), int'(m_phase != 0));
    check("class", int'(result_class), m_class);
    check("count", int'(result_count), m_count);
    check("empty", int'(result_empty), m_empty);
`ifdef CLASSIFIER_MARGIN_EN
    check("margin", int'(result_margin), m_margin);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int g, input int v);
    spike_valid = 1'b1;
    group_idx   = GW'(g);
    spike_i     = NM'(v);
    @(posedge clk); #1;
    spike_valid = 1'b0;
    spike_i     = '0;
  endtask

  task automatic send_n(input int g, input int v, input int n);
    repeat (n) send(g, v);
  endtask

  task automatic finish_pic(input bit with_spike, input int g, input int v);
    picture_done = 1'b1;
    if (with_spike) begin
      spike_valid = 1'b1;
      group_idx   = GW'(g);
      spike_i     = NM'(v);
    end
    @(posedge clk); #1;
    picture_done = 1'b0;
    spike_valid  = 1'b0;
    spike_i      = '0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!result_valid) check("result_timeout", 0, 1);
  endtask

  task automatic accept(input int delay, input bit hold_spikes);
    repeat (delay) begin
      spike_valid = hold_spikes ? 1'($urandom_range(0, 1)) : 1'b0;
      group_idx   = GW'($urandom_range(0, 3));
      spike_i     = NM'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    spike_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", int'(result_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_class", int'(result_class), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic classification
    send_n(0, 4'b0100, 7);
    send_n(1, 4'b0010, 3);
    finish_pic(1'b0, 0, 0);
    wait_valid(lat);
    check("basic_latency", lat, NC + 1);
    check("basic_class", int'(result_class), 2);
    check("basic_count", int'(result_count), 7);
    check("basic_empty", int'(result_empty), 0);
    accept(0, 1'b0);

    // Reset mid-SCAN
    send_n(0, 4'b1000, 5);
    finish_pic(1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midscan_valid", int'(result_valid), 0);
    check("midscan_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (result_valid) seen++;
    end
    check("midscan_no_result", seen, 0);
    finish_pic(1'b0, 0, 0);
    wait_valid(lat);
    check("midscan_cleared_empty", int'(result_empty), 1);
    check("midscan_cleared_count", int'(result_count), 0);
    accept(1, 1'b0);

    // Tie and out-of-range lanes
    send_n(0, 4'b0010, 4);
    send_n(2, 4'b0010, 2);
    send_n(2, 4'b1111, 2);
    finish_pic(1'b0, 0, 0);
    wait_valid(lat);
    check("tie_class", int'(result_class), 1);
    check("tie_count", int'(result_count), 4);
    accept(2, 1'b1);

    // Saturation, then an empty picture
    send_n(0, 4'b0001, 300);
    finish_pic(1'b0, 0, 0);
    wait_valid(lat);
    check("sat_class", int'(result_class), 0);
    check("sat_count", int'(result_count), 255);
    accept(0, 1'b0);
    finish_pic(1'b0, 0, 0);
    wait_valid(lat);
    check("empty_flag", int'(result_empty), 1);
    check("empty_class", int'(result_class), 0);
    accept(0, 1'b0);

    // Same-cycle spike + picture_done, stalled handshake with spikes during HOLD
    send_n(1, 4'b0001, 2);
    send_n(0, 4'b0001, 2);
    finish_pic(1'b1, 1, 4'b0001);
    wait_valid(lat);
    spike_valid = 1'b1;
    group_idx   = GW'(0);
    spike_i     = NM'(4'b0001);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", int'(result_valid), 1);
      check("stall_class", int'(result_class), 4);
      check("stall_count", int'(result_count), 3);
      @(posedge clk); #1;
    end
    spike_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("post_accept_valid", int'(result_valid), 0);
    check("post_accept_busy", int'(busy), 0);
    finish_pic(1'b0, 0, 0);
    wait_valid(lat);
    check("hold_spikes_dropped", int'(result_empty), 1);
    accept(0, 1'b0);

`ifdef CLASSIFIER_MARGIN_EN
    send_n(1, 4'b0001, 10);
    send_n(1, 4'b0100, 7);
    finish_pic(1'b0, 0, 0);
    wait_valid(lat);
    check("margin_class", int'(result_class), 4);
    check("margin_value", int'(result_margin), 3);
    accept(0, 1'b0);
    send_n(1, 4'b0001, 5);
    send_n(1, 4'b0100, 5);
    finish_pic(1'b0, 0, 0);
    wait_valid(lat);
    check("margin_tie_class", int'(result_class), 4);
    check("margin_tie_value", int'(result_margin), 0);
    accept(0, 1'b0);
`endif

    // Randomized pictures against the model
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_n($urandom_range(0, 3), $urandom_range(1, 15), 260);
      end else begin
        int n;
        n = $urandom_range(0, 30);
        for (int s = 0; s < n; s++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end else begin
            send($urandom_range(0, 3), $urandom_range(0, 15));
          end
        end
      end
      finish_pic(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15));
      wait_valid(lat);
      check("rand_latency", lat, NC + 1);
      accept($urandom_range(0, 4), 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nvm_spike_classifier.md
Name: nvm_spike_classifier

Overview:
- Downstream of the NVM neuron block; consumes its 4-lane spike_o vector, one neuron group at a time.
- Accumulates a saturating spike count per output class over one picture.
- On picture_done, runs a sequential argmax over all class counters.
- Returns the winning class through a valid/ready handshake to the readout and host logic.

Parameters:
- NUM_OF_MACRO, 4: spike lanes per sample; equals the neuron-block width.
- NUM_CLASSES, 11: number of output neurons/classes; must be >= 1.
- CNT_W, 8: spike counter width per class; counters saturate.
- GRP_W, 2: width of group_idx; requires 2^GRP_W * NUM_OF_MACRO >= NUM_CLASSES.
- CLS_W, 4: width of result_class; requires 2^CLS_W >= NUM_CLASSES.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- spike_i, input, NUM_OF_MACRO: spike vector from the neuron block.
- spike_valid, input, 1: spike_i is sampled this cycle.
- group_idx, input, GRP_W: lane i maps to class group_idx*NUM_OF_MACRO+i.
- picture_done, input, 1: end-of-picture strobe, shared with the neuron block.
- result_class, output, CLS_W: winning class index.
- result_count, output, CNT_W: spike count of the winning class.
- result_empty, output, 1: all counters were zero at the end of the picture.
- result_valid, output, 1: result fields are valid.
- result_ready, input, 1: consumer accepts the result.
- busy, output, 1: high in SCAN or HOLD.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACCUM; all counters 0; scan index 0; best index/count 0.
  - result_class=0, result_count=0, result_empty=0, result_valid=0, busy=0.
  - Reset asserted mid-SCAN or mid-HOLD aborts immediately; the pending result is lost.
- State ACCUM:
  - On spike_valid, for each lane i with spike_i[i]=1 and class c=group_idx*NUM_OF_MACRO+i < NUM_CLASSES: count[c] += 1.
  - count[c] saturates at 2^CNT_W-1 (no wrap).
  - Lanes with c >= NUM_CLASSES are ignored.
  - picture_done -> SCAN next cycle, with scan index=0, best=0, best_count=0.
  - spike_valid together with picture_done: the sample is accumulated first and is included in the scan.
- State SCAN:
  - Compares one counter per cycle, index 0..NUM_CLASSES-1.
  - Updates best only if count[idx] > best_count (strict), so ties go to the lowest index.
  - After index NUM_CLASSES-1 -> HOLD.
  - spike_valid and picture_done are ignored.
- State HOLD:
  - result_valid=1; result_class, result_count and result_empty are held stable.
  - result_empty = (best_count==0); in that case result_class=0.
  - On result_valid & result_ready: all counters clear, result_valid=0 next cycle, state -> ACCUM.
  - spike_valid and picture_done are ignored; samples are dropped, not buffered.
- Latency: picture_done sampled at edge T -> result_valid high after edge T+NUM_CLASSES+1.
  - If result_ready is held high, accumulation of the next picture starts one cycle after result_valid.
- busy = (state != ACCUM).
  - Upstream must not issue spikes while busy; the neuron block clears its potentials on the same picture_done.
- result_* fields change only on entering HOLD and on reset.

Optional Feature:
- Macro: CLASSIFIER_MARGIN_EN.
- With the macro:
  - SCAN also tracks the second-best count.
  - Adds output result_margin [CNT_W-1:0] = best_count - second_count, valid with result_valid.
  - Margin is 0 on a tie.
  - If NUM_CLASSES==1, margin = best_count.
  - Reset value is 0.
- Without the macro: the port and the second-best register do not exist; all other behaviour is identical.

Decomposition:
- Shared package nvm_snn_pkg holds:
  - state encoding typedef (ACCUM, SCAN, HOLD);
  - NUM_OF_MACRO and NUM_CLASSES defaults;
  - CNT_W/CLS_W defaults;
  - the saturating-increment width constant.
- One natural sub-module: nvm_sat_counter, one saturating CNT_W counter with inc and clr; instantiated NUM_CLASSES times.
- The argmax FSM stays in the top module.

Test Plan:
- Reset mid-SCAN:
  - Stimulus: load count[3]=5, pulse picture_done, drop rst_n 3 cycles later.
  - Required: result_valid=0, busy=0, all counters 0, no result after rst_n rises.
- Basic classification:
  - Stimulus: group 0 spike_i=4'b0100 x7 samples; group 1 spike_i=4'b0010 x3; picture_done.
  - Required: result_valid exactly NUM_CLASSES+1 cycles later; result_class=2, result_count=7, result_empty=0.
- Tie and out-of-range lanes:
  - Stimulus: class 1 and class 9 each 4 spikes; group 2 spike_i=4'b1111 x2 (class 8=2; classes 11 and above ignored).
  - Required: result_class=1, result_count=4.
- Saturation and empty picture:
  - Stimulus: class 0 spiked 300 times with CNT_W=8.
  - Required: result_count=255.
  - Follow-up: next picture has no spikes; required result_empty=1, result_class=0.
- Handshake and simultaneous events:
  - Stimulus: spike_valid and picture_done in the same cycle; result_ready held low for 5 cycles; spikes issued during HOLD.
  - Required: the same-cycle sample is counted; result fields are stable while stalled; HOLD spikes are not counted in the next picture; counters read 0 after the handshake.
- CLASSIFIER_MARGIN_EN:
  - Stimulus: counts class 4=10, class 6=7.
  - Required: result_margin=3.
  - Follow-up: a tie at 5; required result_margin=0.
